// File: rtl/seq_mult_radix4.sv
// Sequential radix-4 multiplier: consumes one two-bit digit of |B| per clock and
// applies the result sign at the end, so signed and unsigned share one datapath.
module seq_mult_radix4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);
  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [PW-1:0]    acc_r;
  logic [CW-1:0]    step_r;
  logic             sign_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [PW-1:0]    p_r;

  logic [PW-1:0]    pp_s;
  logic [PW-1:0]    acc_next_s;
  logic [PW-1:0]    result_s;
  logic             last_s;

  // The most negative input maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign P         = p_r;

  // Partial product of the current digit (multiplicand is pre-shifted by 2k) and the sum it yields
  always_comb begin
    pp_s = {PW{1'b0}};
    case (mplier_r[1:0])
      2'b00:   pp_s = {PW{1'b0}};
      2'b01:   pp_s = mcand_r;
      2'b10:   pp_s = mcand_r << 1;
      2'b11:   pp_s = mcand_r + (mcand_r << 1);
      default: pp_s = {PW{1'b0}};
    endcase
    acc_next_s = acc_r + pp_s;
    last_s     = (step_r == CW'(STEPS - 1));
    if (sign_r) begin
      result_s = ~acc_next_s + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      result_s = acc_next_s;
    end
  end

  // Control FSM with the datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      p_r         <= {PW{1'b0}};
      acc_r       <= {PW{1'b0}};
      mcand_r     <= {PW{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      step_r      <= {CW{1'b0}};
      sign_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r    <= {{WIDTH{1'b0}}, magnitude(A, signed_mode)};
            mplier_r   <= magnitude(B, signed_mode);
            sign_r     <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc_r      <= {PW{1'b0}};
            step_r     <= {CW{1'b0}};
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
          end
        end
        BUSY: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 2;
          mplier_r <= mplier_r >> 2;
          step_r   <= step_r + CW'(1);
          if (last_s) begin
            p_r         <= result_s;
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          // No accept on the hand-off edge: in_ready only rises once IDLE is reached.
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_radix4.sv
// Scoreboard bench for seq_mult_radix4: accepted operand pairs push an arithmetic
// reference result; a monitor pops and compares whenever the product is presented.
`timescale 1ns/1ps
module tb_seq_mult_radix4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] P;

  seq_mult_radix4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .P(P)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             acc_edge;
  } exp_t;

  exp_t           sbq[$];
  int             edges = 0;
  int             n_checks = 0;
  int             n_pass = 0;
  bit             b2b_mode = 1'b0;
  int             last_acc = -1;
  logic [2*W-1:0] last_p = '0;
  logic           prev_ov = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no/unexpected event, expected the specified handshake", name);
  endtask

  // Reference: plain integer multiplication of the operands as interpreted by signed_mode.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sm);
    longint x, y, prod;
    if (sm) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = a;
      y = b;
    end
    prod = x * y;
    return prod[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'h7F;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // Producer: an accepted pair pushes its expected product; reset discards anything in flight.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      last_p = '0;
      last_acc = -1;
    end else if (in_valid && in_ready) begin
      if (b2b_mode && last_acc >= 0) check("b2b_spacing", edges + 1 - last_acc, 6);
      last_acc = edges + 1;
      sbq.push_back('{ref_product(A, B, signed_mode), edges + 1});
    end
  end

  // Monitor: latency on rise, product while presented, P held while not presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          if (!prev_ov) check("latency", edges, sbq[0].acc_edge + 4);
          check("product", P, sbq[0].p);
          if (out_ready) begin
            last_p = sbq[0].p;
            void'(sbq.pop_front());
          end
        end
      end else begin
        check("p_hold", P, last_p);
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       input int stall);
    int n;
    A = a; B = b; signed_mode = sm; in_valid = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) fail_now("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      A = 8'($urandom); B = 8'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) fail_now("done_timeout");
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    if (stall > 0) begin @(posedge clk); #1; out_ready = 1'b1; end
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
  endtask

  initial begin
    int rel;
    in_valid = 1'b0; A = '0; B = '0; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rel = edges;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_p", P, 0);

    do_op(8'd15, 8'd15, 1'b0, 0);
    check("first_accept_edge", last_acc, rel + 1);
    check("p_15x15", P, 16'h00E1);
    do_op(8'd255, 8'd255, 1'b0, 0);
    do_op(8'd0, 8'd200, 1'b0, 0);
    do_op(8'hFD, 8'd5, 1'b1, 0);
    do_op(8'h80, 8'h80, 1'b1, 0);
    check("p_min_x_min", P, 16'h4000);
    do_op(8'h80, 8'h7F, 1'b1, 10);
    check("p_min_x_max", P, 16'hC080);
    do_op(8'h00, 8'h80, 1'b1, 0);

    // Reset during BUSY with in_valid held, then a fresh 6x7.
    A = 8'd100; B = 8'd100; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    A = 8'd6; B = 8'd7;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_p", P, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int n = 0; n < 50 && !out_valid; n++) begin @(posedge clk); #1; end
    if (!out_valid) fail_now("midrst_done_timeout");
    check("midrst_p_42", P, 16'd42);
    @(posedge clk); #1;

    // Back-to-back with operands changing every cycle.
    b2b_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (40) begin
      A = rand_op(); B = rand_op(); signed_mode = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; b2b_mode = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Fully random handshakes on both sides.
    repeat (400) begin
      in_valid = 1'($urandom); A = rand_op(); B = rand_op();
      signed_mode = 1'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_radix4.md
SEQ_MULT_RADIX4 -- requirements
Module: seq_mult_radix4

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  operand pair on A/B/signed_mode is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 A  input  WIDTH  multiplicand.
REQ-007 B  input  WIDTH  multiplier.
REQ-008 signed_mode  input  1  1 = A, B, P two's complement; 0 = unsigned.
REQ-009 out_valid  output  1  P holds a finished product.
REQ-010 out_ready  input  1  consumer accepts P.
REQ-011 P  output  2*WIDTH  product.

Function
REQ-012 States SHALL be IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-013 IDLE: on an edge with in_valid=1, the block SHALL capture |A|, |B| (magnitudes if signed_mode=1, raw otherwise) and the result sign (A[MSB] xor B[MSB] when signed; 0 when unsigned), clear the accumulator and step counter, and enter BUSY.
REQ-014 IDLE with in_valid=0 SHALL hold all state.
REQ-015 BUSY: each edge SHALL add (|A| * two-bit digit of |B| at step k) << 2k to the accumulator, LSB digit first, k = 0 .. WIDTH/2-1, then increment k.
REQ-016 Partial-product and accumulator arithmetic SHALL be 2*WIDTH bits wide with no truncation of any intermediate.
REQ-017 On the edge processing k = WIDTH/2-1, the block SHALL load P with the accumulated product, two's-complement negated if the result sign is 1, and enter DONE.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH/2 edges after the accept edge (4 edges for WIDTH=8).
REQ-019 Magnitude of the most negative operand (-2^(WIDTH-1)) SHALL be represented as unsigned 2^(WIDTH-1) without overflow.
REQ-020 DONE: P and out_valid SHALL hold stable while out_ready=0 (unbounded stall).
REQ-021 DONE with out_ready=1 on an edge SHALL return to IDLE and drop out_valid; a new operand SHALL NOT be accepted on that edge.
REQ-022 A, B, signed_mode changes while in BUSY or DONE SHALL NOT affect the result in flight.
REQ-023 P SHALL hold its last value after leaving DONE until the next DONE entry.
REQ-024 Zero operands SHALL give P = 0 with out_valid at normal latency (no early exit).

Reset
REQ-025 rst=1 on an edge SHALL force IDLE, in_ready=1, out_valid=0, P=0, and accumulator, counter and sign to 0, overriding any in_valid or out_ready on that edge.
REQ-026 rst asserted in BUSY or DONE SHALL abandon the operation; no out_valid SHALL follow for it.
REQ-027 The first accept SHALL be possible on the first edge after rst deasserts.

Verification (WIDTH=8)
REQ-028 unsigned A=15, B=15 -> P=0x00E1 (225), out_valid 4 edges after accept.
REQ-029 unsigned A=255, B=255 -> P=0xFE01 (65025); A=0, B=200 -> P=0 at same latency.
REQ-030 signed A=-3 (0xFD), B=5 -> P=0xFFF1 (-15); signed A=-128, B=-128 -> P=0x4000 (16384); signed A=-128, B=127 -> P=0xC080.
REQ-031 out_ready held 0 for 10 cycles in DONE -> P, out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-032 rst pulsed on edge 2 of BUSY, in_valid held 1 -> IDLE with P=0 after reset; new pair 6x7 accepted after rst deasserts -> P=42, no stale result.
REQ-033 Back-to-back pairs with in_valid held 1, out_ready=1 -> one result per 6 edges, each correct, operands changing mid-BUSY ignored.
